index_encoder_seq: RTL



---
 rtl/index_encoder_seq_pkg.sv | 23 ++
 rtl/index_encoder_seq_if.sv | 24 ++
 rtl/index_encoder_seq_lowest_set_encoder.sv | 24 ++
 rtl/index_encoder_seq.sv | 90 +++++++++
 4 files changed

// File: rtl/index_encoder_seq_pkg.sv
// Shared types and helpers for the multi-hot mask to index serialiser.
package index_enc_pkg;

    localparam int N_DEF   = 32;
    localparam int W_DEF   = $clog2(N_DEF);
    localparam int POP_MAX = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Callers zero-extend narrower masks to POP_MAX bits.
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/index_encoder_seq_if.sv
// Load / output handshake bundle for index_encoder_seq.
interface index_encoder_seq_if #(
    parameter int N = 32,
    parameter int W = $clog2(N)
);
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] load_mask;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_index;
    logic         out_last;
    logic [W:0]   remaining;

    modport master (
        output load_valid, load_mask, out_ready,
        input  load_ready, out_valid, out_index, out_last, remaining
    );

    modport slave (
        input  load_valid, load_mask, out_ready,
        output load_ready, out_valid, out_index, out_last, remaining
    );
endinterface

// File: rtl/index_encoder_seq_lowest_set_encoder.sv
// Combinational priority encoder: binary index of the lowest set bit.
module lowest_set_encoder
    import index_enc_pkg::*;
#(
    parameter int N = N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx = W'(i);
            end
        end
        found = |in;
    end

endmodule

// File: rtl/index_encoder_seq.sv
// Serialises a multi-hot mask into ascending binary indices, one per handshake.
//
// state | meaning
// IDLE  | load_ready high, waiting for a mask
// DRAIN | emitting pending indices lowest first
module index_encoder_seq
    import index_enc_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic              clk,
    input  logic              reset,
    index_encoder_seq_if.slave bus
);

    localparam int W = $clog2(N);

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W:0]   remaining_q, remaining_d;

    logic [W-1:0] lse_idx;
    logic         lse_found;

    logic         load_ready;
    logic         out_valid;
    logic [W-1:0] out_index;
    logic         out_last;

    lowest_set_encoder #(.N(N)) u_lse (
        .in    (pending_q),
        .idx   (lse_idx),
        .found (lse_found)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        remaining_d = remaining_q;
        load_ready  = 1'b0;
        out_valid   = 1'b0;
        out_index   = '0;
        out_last    = 1'b0;

        unique case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                // An all-zero mask completes the handshake but produces nothing.
                if (bus.load_valid && (bus.load_mask != '0)) begin
                    pending_d   = bus.load_mask;
                    remaining_d = (W+1)'(popcount(POP_MAX'(bus.load_mask)));
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = lse_found;
                out_index = lse_idx;
                out_last  = (remaining_q == (W+1)'(1));
                if (bus.out_ready) begin
                    // x & (x-1) drops exactly the lowest set bit.
                    pending_d   = pending_q & (pending_q - N'(1));
                    remaining_d = remaining_q - (W+1)'(1);
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_index  = out_index;
    assign bus.out_last   = out_last;
    assign bus.remaining  = remaining_q;

endmodule
